// File: rtl/jpeg_rle_symbol_encoder_if.sv
// Handshake bundle between the quantizer, the run/size symbol encoder and the Huffman stage.
interface jpeg_rle_symbol_encoder_if #(
    parameter int COEF_W = 11,
    parameter int AMP_W  = 11
);
    logic                     dc_clr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_coef;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_run;
    logic [3:0]               out_size;
    logic [AMP_W-1:0]         out_amp;
    logic                     out_dc;
    logic                     out_eob;

    modport master (
        output dc_clr, in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_run, out_size, out_amp, out_dc, out_eob
    );

    modport slave (
        input  dc_clr, in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_run, out_size, out_amp, out_dc, out_eob
    );
endinterface

// File: rtl/jpeg_rle_symbol_encoder.sv
// JPEG entropy front end: DC prediction, zero-run counting, ZRL/EOB insertion,
// one output register so every accepted coefficient's symbol appears next cycle.
module jpeg_rle_symbol_encoder #(
    parameter int COEF_W = 11,
    parameter int AMP_W  = 11
) (
    input logic                       clk,
    input logic                       rst,
    jpeg_rle_symbol_encoder_if.slave  bus
);
    typedef enum logic [1:0] {S_DC, S_AC, S_ZRL} state_e;

    state_e                   state_q, state_d;
    logic signed [COEF_W-1:0] pred_q, pred_d;
    logic signed [COEF_W-1:0] hold_q, hold_d;
    logic [5:0]               idx_q, idx_d;
    logic [3:0]               zrun_q, zrun_d;
    logic [1:0]               zpend_q, zpend_d;

    logic                     out_valid_q, out_valid_d;
    logic [3:0]               out_run_q, out_run_d;
    logic [3:0]               out_size_q, out_size_d;
    logic [AMP_W-1:0]         out_amp_q, out_amp_d;
    logic                     out_dc_q, out_dc_d;
    logic                     out_eob_q, out_eob_d;

    logic                     slot, accept, coef_zero, last;
    logic                     emit, emit_dc, emit_eob;
    logic [3:0]               emit_run;
    logic signed [COEF_W:0]   sym_val;
    logic [3:0]               sym_size;

    function automatic logic [3:0] size_of(input logic signed [COEF_W:0] v);
        logic [COEF_W:0] mag;
        logic [3:0]      s;
        mag = v[COEF_W] ? -v : v;
        s   = '0;
        for (int unsigned i = 0; i <= COEF_W; i++)
            if (mag[i]) s = 4'(i + 1);
        return s;
    endfunction

    // Negative values carry the one's complement of |v|, i.e. (v-1) truncated.
    function automatic logic [AMP_W-1:0] amp_of(input logic signed [COEF_W:0] v,
                                                input logic [3:0]          s);
        logic [AMP_W-1:0] t;
        logic [AMP_W-1:0] mask;
        t    = AMP_W'(v[COEF_W] ? v - {{COEF_W{1'b0}}, 1'b1} : v);
        mask = ~({AMP_W{1'b1}} << s);
        return t & mask;
    endfunction

    assign slot         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = slot && (state_q != S_ZRL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign coef_zero    = (bus.in_coef == '0);
    assign last         = (idx_q == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DC;
            pred_q      <= '0;
            hold_q      <= '0;
            idx_q       <= '0;
            zrun_q      <= '0;
            zpend_q     <= '0;
            out_valid_q <= 1'b0;
            out_run_q   <= '0;
            out_size_q  <= '0;
            out_amp_q   <= '0;
            out_dc_q    <= 1'b0;
            out_eob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            zrun_q      <= zrun_d;
            zpend_q     <= zpend_d;
            out_valid_q <= out_valid_d;
            out_run_q   <= out_run_d;
            out_size_q  <= out_size_d;
            out_amp_q   <= out_amp_d;
            out_dc_q    <= out_dc_d;
            out_eob_q   <= out_eob_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        zrun_d   = zrun_q;
        zpend_d  = zpend_q;
        emit     = 1'b0;
        emit_dc  = 1'b0;
        emit_eob = 1'b0;
        emit_run = '0;
        sym_val  = '0;
        if (state_q == S_DC && bus.dc_clr) pred_d = '0;
        case (state_q)
            S_DC: begin
                if (accept) begin
                    sym_val = {bus.in_coef[COEF_W-1], bus.in_coef}
                            - (bus.dc_clr ? '0 : {pred_q[COEF_W-1], pred_q});
                    emit    = 1'b1;
                    emit_dc = 1'b1;
                    pred_d  = bus.in_coef;
                    idx_d   = idx_q + 6'd1;
                    state_d = S_AC;
                end
            end
            S_AC: begin
                if (accept) begin
                    idx_d = idx_q + 6'd1;
                    if (coef_zero) begin
                        if (last) begin
                            emit     = 1'b1;
                            emit_eob = 1'b1;
                            zrun_d   = '0;
                            zpend_d  = '0;
                            state_d  = S_DC;
                        end else if (zrun_q == 4'd15) begin
                            zrun_d  = '0;
                            zpend_d = zpend_q + 2'd1;
                        end else begin
                            zrun_d = zrun_q + 4'd1;
                        end
                    end else if (zpend_q == '0) begin
                        emit     = 1'b1;
                        emit_run = zrun_q;
                        sym_val  = {bus.in_coef[COEF_W-1], bus.in_coef};
                        zrun_d   = '0;
                        if (last) state_d = S_DC;
                    end else begin
                        hold_d  = bus.in_coef;
                        state_d = S_ZRL;
                    end
                end
            end
            S_ZRL: begin
                if (slot) begin
                    emit = 1'b1;
                    if (zpend_q != '0) begin
                        emit_run = 4'd15;
                        zpend_d  = zpend_q - 2'd1;
                    end else begin
                        emit_run = zrun_q;
                        sym_val  = {hold_q[COEF_W-1], hold_q};
                        zrun_d   = '0;
                        // idx has already wrapped when the held coefficient closed the block
                        state_d  = (idx_q == '0) ? S_DC : S_AC;
                    end
                end
            end
            default: state_d = S_DC;
        endcase
    end

    assign sym_size = size_of(sym_val);

    always_comb begin
        out_valid_d = out_valid_q;
        out_run_d   = out_run_q;
        out_size_d  = out_size_q;
        out_amp_d   = out_amp_q;
        out_dc_d    = out_dc_q;
        out_eob_d   = out_eob_q;
        if (slot) begin
            out_valid_d = emit;
            if (emit) begin
                out_run_d  = emit_run;
                out_size_d = sym_size;
                out_amp_d  = amp_of(sym_val, sym_size);
                out_dc_d   = emit_dc;
                out_eob_d  = emit_eob;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_run   = out_run_q;
    assign bus.out_size  = out_size_q;
    assign bus.out_amp   = out_amp_q;
    assign bus.out_dc    = out_dc_q;
    assign bus.out_eob   = out_eob_q;
endmodule

// File: tb/tb_jpeg_rle_symbol_encoder.sv
// Bench for jpeg_rle_symbol_encoder: directed block scenarios plus random blocks
// with random output stalls, checked against a block-level symbol model.
module tb_jpeg_rle_symbol_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jpeg_rle_symbol_encoder_if #(.COEF_W(11), .AMP_W(11)) bus ();

    jpeg_rle_symbol_encoder #(.COEF_W(11), .AMP_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [10:0] blk [64];
    logic [20:0]        got [$];
    logic               got_rdy [$];
    logic [20:0]        exp_q [$];
    int                 mdl_pred = 0;
    int                 ready_mode = 0;   // 0 always ready, 1 random, 2 stalled

    function automatic logic [20:0] cur_sym();
        return {bus.out_dc, bus.out_eob, bus.out_run, bus.out_size, bus.out_amp};
    endfunction

    // Symbol from the JPEG category rules: size = bit length of |v|.
    function automatic logic [20:0] mk(input bit dc, input bit eob, input int run, input int v);
        int s, m, a;
        m = (v < 0) ? -v : v;
        s = 0;
        while (m > 0) begin s++; m = m / 2; end
        a = (v >= 0) ? v : v - 1 + (1 << s);
        return {dc, eob, 4'(run), 4'(s), 11'(a)};
    endfunction

    function automatic void model_block(input bit clr);
        int d, run;
        if (clr) mdl_pred = 0;
        d = int'(blk[0]) - mdl_pred;
        mdl_pred = int'(blk[0]);
        exp_q.push_back(mk(1'b1, 1'b0, 0, d));
        run = 0;
        for (int i = 1; i < 64; i++) begin
            if (blk[i] == 0) run++;
            else begin
                while (run >= 16) begin exp_q.push_back(mk(1'b0, 1'b0, 15, 0)); run -= 16; end
                exp_q.push_back(mk(1'b0, 1'b0, run, int'(blk[i])));
                run = 0;
            end
        end
        if (blk[63] == 0) exp_q.push_back(mk(1'b0, 1'b1, 0, 0));
    endfunction

    function automatic logic signed [10:0] rand_nz();
        int s, m;
        s = int'($urandom_range(1, 10));
        m = int'($urandom_range((1 << (s - 1)), (1 << s) - 1));
        if (s == 10 && $urandom_range(0, 3) == 0) m = 1023;
        return ($urandom_range(0, 1) == 1) ? 11'(-m) : 11'(m);
    endfunction

    function automatic void clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endfunction

    always begin
        @(negedge clk);
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b0;
        endcase
        #1;
        if (bus.out_valid && bus.out_ready) begin
            got.push_back(cur_sym());
            got_rdy.push_back(bus.in_ready);
        end
    end

    task automatic send_coef(input logic signed [10:0] c, input bit clr);
        int n = 0;
        @(negedge clk); #2;
        bus.in_valid = 1'b1;
        bus.in_coef  = c;
        bus.dc_clr   = clr;
        while (!bus.in_ready && n < 1000) begin @(negedge clk); #2; n++; end
        if (n >= 1000) begin
            checks++; failures++;
            $display("FAIL accept_timeout got=in_ready_low exp=accept_within_1000");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dc_clr   = 1'b0;
    endtask

    task automatic send_block(input bit clr);
        for (int i = 0; i < 64; i++) send_coef(blk[i], clr && (i == 0));
    endtask

    task automatic drain();
        int n = 0;
        while (got.size() < exp_q.size() && n < 3000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
    endtask

    task automatic flush_queues();
        got.delete(); got_rdy.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_coef = '0; bus.dc_clr = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (cur_sym() !== 21'h0) begin failures++; $display("FAIL reset_fields got=%h exp=0", cur_sym()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        rst = 1'b0;
        flush_queues();
        mdl_pred = 0;
    endtask

    task automatic test_dc_eob();
        clear_blk(); blk[0] = 11'sd5;
        model_block(1'b0); send_block(1'b0); drain();
        checks++;
        if (got.size() !== 2) begin failures++; $display("FAIL dc_eob_count got=%0d exp=2", got.size()); end
        if (got.size() >= 2) begin
            checks++;
            if (got[0] !== {1'b1, 1'b0, 4'd0, 4'd3, 11'b101}) begin failures++; $display("FAIL dc_plus5 got=%h exp=%h", got[0], {1'b1, 1'b0, 4'd0, 4'd3, 11'b101}); end
            checks++;
            if (got[1] !== {1'b0, 1'b1, 4'd0, 4'd0, 11'd0}) begin failures++; $display("FAIL eob got=%h exp=%h", got[1], {1'b0, 1'b1, 4'd0, 4'd0, 11'd0}); end
        end
        flush_queues();
    endtask

    task automatic test_dc_pred();
        clear_blk(); blk[0] = 11'sd2;
        model_block(1'b0); send_block(1'b0);
        model_block(1'b1); send_block(1'b1);
        drain();
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL dc_pred_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        if (got.size() >= 4) begin
            checks++;
            if (got[0] !== {1'b1, 1'b0, 4'd0, 4'd2, 11'b00}) begin failures++; $display("FAIL dc_diff_minus3 got=%h exp=%h", got[0], {1'b1, 1'b0, 4'd0, 4'd2, 11'b00}); end
            checks++;
            if (got[2] !== {1'b1, 1'b0, 4'd0, 4'd2, 11'b10}) begin failures++; $display("FAIL dc_after_clr got=%h exp=%h", got[2], {1'b1, 1'b0, 4'd0, 4'd2, 11'b10}); end
        end
        flush_queues();
    endtask

    task automatic test_zrl();
        clear_blk(); blk[0] = 11'sd2; blk[21] = 11'sd7;
        model_block(1'b0); send_block(1'b0); drain();
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL zrl_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL zrl_sym[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        if (got.size() >= 3) begin
            checks++;
            if (got[1] !== {1'b0, 1'b0, 4'd15, 4'd0, 11'd0}) begin failures++; $display("FAIL zrl_symbol got=%h exp=%h", got[1], {1'b0, 1'b0, 4'd15, 4'd0, 11'd0}); end
            checks++;
            if (got_rdy[1] !== 1'b0) begin failures++; $display("FAIL zrl_in_ready got=%b exp=0", got_rdy[1]); end
            checks++;
            if (got[2] !== {1'b0, 1'b0, 4'd4, 4'd3, 11'b111}) begin failures++; $display("FAIL zrl_held got=%h exp=%h", got[2], {1'b0, 1'b0, 4'd4, 4'd3, 11'b111}); end
            checks++;
            if (got_rdy[2] !== 1'b1) begin failures++; $display("FAIL held_in_ready got=%b exp=1", got_rdy[2]); end
        end
        flush_queues();
    endtask

    task automatic test_last_nonzero();
        clear_blk(); blk[0] = -11'sd9; blk[63] = -11'sd1;
        model_block(1'b0); send_block(1'b0);
        clear_blk(); blk[0] = 11'sd3;
        model_block(1'b0); send_block(1'b0);
        drain();
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL last_nz_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL last_nz_sym[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        if (got.size() >= 6) begin
            checks++;
            if (got[4] !== {1'b0, 1'b0, 4'd14, 4'd1, 11'd0}) begin failures++; $display("FAIL idx63_minus1 got=%h exp=%h", got[4], {1'b0, 1'b0, 4'd14, 4'd1, 11'd0}); end
            checks++;
            if (got[5][20] !== 1'b1) begin failures++; $display("FAIL next_is_dc got=%b exp=1", got[5][20]); end
        end
        flush_queues();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 64; i++) blk[i] = rand_nz();
        model_block(1'b0);
        fork
            send_block(1'b0);
            begin
                int n = 0;
                logic [20:0] snap;
                snap = '0;
                while (got.size() < 5 && n < 500) begin @(negedge clk); n++; end
                #3 ready_mode = 2;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #2;
                    checks++;
                    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, bus.out_valid); end
                    checks++;
                    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, bus.in_ready); end
                    if (k == 0) snap = cur_sym();
                    else begin
                        checks++;
                        if (cur_sym() !== snap) begin failures++; $display("FAIL stall_stable[%0d] got=%h exp=%h", k, cur_sym(), snap); end
                    end
                end
                ready_mode = 0;
            end
        join
        drain();
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL stall_sym[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        flush_queues();
    endtask

    task automatic test_random_blocks();
        ready_mode = 1;
        for (int b = 0; b < 100; b++) begin
            int zp;
            bit clr;
            zp = int'($urandom_range(50, 98));
            for (int i = 0; i < 64; i++)
                blk[i] = (int'($urandom_range(0, 99)) < zp) ? 11'sd0 : rand_nz();
            if (b % 5 == 0) blk[63] = rand_nz();
            clr = ($urandom_range(0, 7) == 0);
            model_block(clr);
            send_block(clr);
        end
        drain();
        ready_mode = 0;
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL random_sym[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        flush_queues();
    endtask

    task automatic test_reset_mid();
        ready_mode = 0;
        clear_blk(); blk[0] = 11'sd6;
        for (int i = 0; i < 30; i++) send_coef(blk[i], 1'b0);
        ready_mode = 2;
        send_coef(11'sd3, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_pending got=%b exp=1", bus.out_valid); end
        rst = 1'b1;
        @(negedge clk); #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", bus.in_ready); end
        rst = 1'b0;
        flush_queues();
        mdl_pred = 0;
        ready_mode = 0;
        clear_blk(); blk[0] = 11'sd4; blk[5] = -11'sd2;
        model_block(1'b0); send_block(1'b0); drain();
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL post_rst_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL post_rst_sym[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        if (got.size() >= 1) begin
            checks++;
            if (got[0] !== {1'b1, 1'b0, 4'd0, 4'd3, 11'd4}) begin failures++; $display("FAIL post_rst_dc got=%h exp=%h", got[0], {1'b1, 1'b0, 4'd0, 4'd3, 11'd4}); end
        end
        flush_queues();
    endtask

    initial begin
        test_reset();
        test_dc_eob();
        test_dc_pred();
        test_zrl();
        test_last_nonzero();
        test_stall();
        test_random_blocks();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
